ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the toy MIPS pipeline: consumes the decoded operation latched by the ID/EX register and produces the EX/MEM-bound result. Logic ops complete combinationally. MULT/MULTU/DIV/DIVU run on an iterative 32-step multiply/divide engine that owns the HI/LO registers, and the stage holds the front of the pipeline through `stall_req` until the operation finishes.

## Interface
Parameters: none. Widths come from `define.v`.

- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, synchronous and active-low (0 = reset).
- `ex_alusel`, in, `ALU_SEL_BUS` [2:0]: `ALU_NOP`=0, `ALU_LOGIC`=1, `ALU_MULDIV`=2.
- `ex_aluop`, in, `EX_OP_LOW_BUS` [2:0]: sub-op.
  - LOGIC: AND=0, OR=1, XOR=2, NOR=3.
  - MULDIV: MULT=0, MULTU=1, DIV=2, DIVU=3, MFHI=4, MFLO=5, MTHI=6, MTLO=7.
- `ex_srcLeft`, `ex_srcRight`, in, 32: operands.
- `ex_offset`, in, 32: address offset for memory ops.
- `ex_memop`, in, `MEM_OP_BUS` [2:0]: forwarded memory op (`MEM_OP_NOP`=0).
- `ex_dest`, in, 5: destination GPR.
- `ex_writeEnable`, in, 1: GPR write request.
- `mem_wdata`, out, 32: result.
- `mem_addr`, out, 32: `ex_srcLeft + ex_offset`, mod 2^32.
- `mem_memop`, `mem_dest`, `mem_writeEnable`, out: forwarded fields, or a bubble (see below).
- `stall_req`, out, 1: hold PC/IF_ID/ID_EX this cycle.
- `hi`, `lo`, out, 32: current HI/LO values, for debug.

## Operation
- LOGIC: `mem_wdata` = srcLeft op srcRight. NOR = ~(L|R). Other fields pass through.
- NOP alusel: `mem_wdata`=0. Other fields pass through.
- MFHI/MFLO: `mem_wdata` = HI/LO register value. `ex_writeEnable` and `ex_dest` pass through.
- MTHI/MTLO: write srcLeft into HI/LO at the clock edge. `mem_wdata`=0 and `mem_writeEnable`=0.
- Engine FSM states: IDLE, MUL, DIV, DONE. 5-bit step counter.
  - IDLE → MUL/DIV on MULT/MULTU/DIV/DIVU. Latch |operands| (signed ops) or raw operands (unsigned ops), plus result sign flags. Counter is cleared to 0.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring division, one quotient bit per cycle, 64-bit remainder/quotient shift register.
  - MUL/DIV → DONE after step 31, i.e. 32 iteration cycles.
  - DONE: apply sign correction and write HI/LO at the edge, then go to IDLE.
  - MUL result: HI = product[63:32], LO = product[31:0]. Signed product is negated when the operand signs differ.
  - DIV result: LO = quotient, negated when the signs differ. HI = remainder, taking the sign of the dividend.
- Divide by zero: still 33 cycles. LO=0xFFFFFFFF, HI=dividend. Signedness is ignored.
- Signed DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Bubble: in every cycle where `stall_req`=1, `mem_writeEnable`=0, `mem_memop`=`MEM_OP_NOP`, `mem_dest`=0, `mem_wdata`=0.
- Reset (`rst`=0), also mid-operation: FSM→IDLE, counter=0, HI=LO=0, engine operands cleared. `stall_req` drops in the same cycle. The next op starts clean.

## Timing
- Outputs are combinational from the inputs and state. Latency to EX/MEM: same cycle.
- Mul/div op presented in cycle 0 (state IDLE):
  - `stall_req`=1 combinationally in cycle 0 and in cycles 1..32.
  - Cycle 33 (DONE): `stall_req`=0 and HI/LO are written at the end-of-cycle edge.
  - ID_EX advances on that same edge.
  - Total 34 cycles in EX.
- ID_EX holds the same inputs while stalled. The engine ignores its start condition outside IDLE, so the op never restarts.
- In DONE the inputs still hold the finished op. The engine does not restart, because it returns to IDLE at that edge and the next op arrives.
- MFHI/MFLO immediately following MULT/DIV read the updated HI/LO; no extra forwarding is needed.
- MTHI followed by MFHI: the new value is visible in the next cycle.
- All outputs are 0 during reset. `hi`/`lo` read 0 the cycle after reset.

## Structure
- `define.v` holds all constants:
  - `ALU_MULDIV`.
  - sub-op codes `EX_MULDIV_*` and `EX_LOGIC_*`.
  - FSM state codes `MD_IDLE`/`MD_MUL`/`MD_DIV`/`MD_DONE`.
  - `HI_LO_RESET`.
- One sub-module, `muldiv_unit`. It contains the FSM, counter, shift registers and HI/LO, with a start/op/operand input and busy/hi/lo outputs.
- `ex_stage` contains the logic mux, address adder, bubble insertion and `stall_req = start_pending | busy`.

## Test plan
- LOGIC NOR, L=0x0F0F0000, R=0x00FF00FF, writeEnable=1, dest=8 → `mem_wdata`=0xF000FF00, `mem_writeEnable`=1, `mem_dest`=8, no stall.
- MULT, L=0xFFFFFFFE (−2), R=3 → `stall_req` high exactly 33 cycles, bubbles throughout; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. A following MFLO gives `mem_wdata`=0xFFFFFFFA.
- MULTU, L=R=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV, L=−7, R=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU, L=100, R=0 → LO=0xFFFFFFFF, HI=100, still 33 stall cycles. Signed 0x80000000/−1 → LO=0x80000000, HI=0.
- `rst`=0 at cycle 10 of a DIV → same-cycle `stall_req`=0, HI=LO=0. After release, MTHI 0x1234 then MFHI → `mem_wdata`=0x1234.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ============================================================================
// ex_stage_pkg : shared constants, engine state type and helpers for ex_stage
// Rev 1.0
// ============================================================================
`default_nettype none

package ex_stage_pkg;

    localparam logic [2:0] ALU_NOP    = 3'd0;
    localparam logic [2:0] ALU_LOGIC  = 3'd1;
    localparam logic [2:0] ALU_MULDIV = 3'd2;

    localparam logic [2:0] EX_LOGIC_AND = 3'd0;
    localparam logic [2:0] EX_LOGIC_OR  = 3'd1;
    localparam logic [2:0] EX_LOGIC_XOR = 3'd2;
    localparam logic [2:0] EX_LOGIC_NOR = 3'd3;

    localparam logic [2:0] EX_MULDIV_MULT  = 3'd0;
    localparam logic [2:0] EX_MULDIV_MULTU = 3'd1;
    localparam logic [2:0] EX_MULDIV_DIV   = 3'd2;
    localparam logic [2:0] EX_MULDIV_DIVU  = 3'd3;
    localparam logic [2:0] EX_MULDIV_MFHI  = 3'd4;
    localparam logic [2:0] EX_MULDIV_MFLO  = 3'd5;
    localparam logic [2:0] EX_MULDIV_MTHI  = 3'd6;
    localparam logic [2:0] EX_MULDIV_MTLO  = 3'd7;

    localparam logic [2:0]  MEM_OP_NOP  = 3'd0;
    localparam logic [31:0] HI_LO_RESET = 32'h0000_0000;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_if.sv
// ============================================================================
// ex_stage_if : ID/EX inputs and EX/MEM outputs of the execute stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface ex_stage_if;
    logic [2:0]  ex_alusel;
    logic [2:0]  ex_aluop;
    logic [31:0] ex_srcLeft;
    logic [31:0] ex_srcRight;
    logic [31:0] ex_offset;
    logic [2:0]  ex_memop;
    logic [4:0]  ex_dest;
    logic        ex_writeEnable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [2:0]  mem_memop;
    logic [4:0]  mem_dest;
    logic        mem_writeEnable;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight, ex_offset,
               ex_memop, ex_dest, ex_writeEnable,
        input  mem_wdata, mem_addr, mem_memop, mem_dest, mem_writeEnable,
               stall_req, hi, lo
    );

    modport slave (
        input  ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight, ex_offset,
               ex_memop, ex_dest, ex_writeEnable,
        output mem_wdata, mem_addr, mem_memop, mem_dest, mem_writeEnable,
               stall_req, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/ex_stage_muldiv.sv
// ============================================================================
// muldiv_unit : iterative 32-step multiply/divide engine owning HI/LO
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic        idle,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state, state_nxt;
    logic [4:0]  cnt;
    logic [63:0] acc;      // MUL: product accumulator; DIV: remainder:quotient
    logic [63:0] mcand;
    logic [31:0] opb;      // MUL: multiplier (shifted right); DIV: divisor
    logic        div_op, neg_res, neg_rem;
    logic [31:0] hi_r, lo_r;

    // Divide-by-zero runs unsigned on raw operands so the restoring loop
    // naturally yields quotient all-ones and remainder = dividend.
    logic        sgn;
    logic [31:0] a_in, b_in;
    logic [32:0] diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        sgn      = ~op[0] & ~(op[1] & (src_b == 32'd0));
        a_in     = sgn ? abs32(src_a) : src_a;
        b_in     = sgn ? abs32(src_b) : src_b;
        diff     = acc[63:31] - {1'b0, opb};
        prod_fix = neg_res ? (~acc + 64'd1) : acc;
        quo_fix  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = op[1] ? MD_DIV : MD_MUL;
            MD_MUL,
            MD_DIV:  if (cnt == 5'd31) state_nxt = MD_DONE;
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= MD_IDLE;
            cnt     <= 5'd0;
            acc     <= 64'd0;
            mcand   <= 64'd0;
            opb     <= 32'd0;
            div_op  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_r    <= HI_LO_RESET;
            lo_r    <= HI_LO_RESET;
        end else begin
            state <= state_nxt;
            case (state)
                MD_IDLE: begin
                    cnt <= 5'd0;
                    if (start) begin
                        div_op  <= op[1];
                        neg_res <= sgn & (src_a[31] ^ src_b[31]);
                        neg_rem <= sgn & src_a[31];
                        opb     <= b_in;
                        acc     <= op[1] ? {32'd0, a_in} : 64'd0;
                        mcand   <= op[1] ? 64'd0 : {32'd0, a_in};
                    end else begin
                        if (mt_hi) hi_r <= mt_data;
                        if (mt_lo) lo_r <= mt_data;
                    end
                end
                MD_MUL: begin
                    cnt <= cnt + 5'd1;
                    if (opb[0]) acc <= acc + mcand;
                    mcand <= {mcand[62:0], 1'b0};
                    opb   <= {1'b0, opb[31:1]};
                end
                MD_DIV: begin
                    cnt <= cnt + 5'd1;
                    if (!diff[32]) acc <= {diff[31:0], acc[30:0], 1'b1};
                    else           acc <= {acc[62:0], 1'b0};
                end
                MD_DONE: begin
                    hi_r <= div_op ? rem_fix : prod_fix[63:32];
                    lo_r <= div_op ? quo_fix : prod_fix[31:0];
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == MD_MUL) || (state == MD_DIV);
    assign idle = (state == MD_IDLE);
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage : execute stage - logic ops, address adder, mul/div stall control
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_stage
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    logic        md_sel, start, mt_hi, mt_lo;
    logic        md_busy, md_idle, stall;
    logic [31:0] md_hi, md_lo;
    logic [31:0] wdata;
    logic        we;

    assign md_sel = (bus.ex_alusel == ALU_MULDIV);
    assign start  = md_sel && !bus.ex_aluop[2];
    assign mt_hi  = md_sel && (bus.ex_aluop == EX_MULDIV_MTHI);
    assign mt_lo  = md_sel && (bus.ex_aluop == EX_MULDIV_MTLO);

    muldiv_unit u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (bus.ex_aluop[1:0]),
        .src_a   (bus.ex_srcLeft),
        .src_b   (bus.ex_srcRight),
        .mt_hi   (mt_hi),
        .mt_lo   (mt_lo),
        .mt_data (bus.ex_srcLeft),
        .busy    (md_busy),
        .idle    (md_idle),
        .hi      (md_hi),
        .lo      (md_lo)
    );

    // The start term covers the issue cycle, before the engine leaves IDLE.
    assign stall = rst && ((start && md_idle) || md_busy);

    always_comb begin
        wdata = 32'd0;
        we    = bus.ex_writeEnable;
        case (bus.ex_alusel)
            ALU_LOGIC: begin
                case (bus.ex_aluop)
                    EX_LOGIC_AND: wdata = bus.ex_srcLeft & bus.ex_srcRight;
                    EX_LOGIC_OR:  wdata = bus.ex_srcLeft | bus.ex_srcRight;
                    EX_LOGIC_XOR: wdata = bus.ex_srcLeft ^ bus.ex_srcRight;
                    EX_LOGIC_NOR: wdata = ~(bus.ex_srcLeft | bus.ex_srcRight);
                    default:      wdata = 32'd0;
                endcase
            end
            ALU_MULDIV: begin
                case (bus.ex_aluop)
                    EX_MULDIV_MFHI: wdata = md_hi;
                    EX_MULDIV_MFLO: wdata = md_lo;
                    EX_MULDIV_MTHI,
                    EX_MULDIV_MTLO: we = 1'b0;
                    default:        wdata = 32'd0;
                endcase
            end
            default: wdata = 32'd0;
        endcase
    end

    assign bus.stall_req       = stall;
    assign bus.mem_wdata       = (rst && !stall) ? wdata : 32'd0;
    assign bus.mem_writeEnable = rst && !stall && we;
    assign bus.mem_memop       = (rst && !stall) ? bus.ex_memop : MEM_OP_NOP;
    assign bus.mem_dest        = (rst && !stall) ? bus.ex_dest : 5'd0;
    assign bus.mem_addr        = rst ? (bus.ex_srcLeft + bus.ex_offset) : 32'd0;
    assign bus.hi              = rst ? md_hi : 32'd0;
    assign bus.lo              = rst ? md_lo : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// tb_ex_stage : scoreboard bench for ex_stage with directed vectors
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam logic [31:0] OFF = 32'h0000_0010;

    typedef struct {
        string       name;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic        we;
        logic [4:0]  dest;
        logic [2:0]  memop;
        int          stalls;
        bit          chk_hilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sbq[$];
    int   checks    = 0;
    int   failures  = 0;
    int   stall_cnt = 0;
    bit   active    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [2:0] op,
                         input logic [31:0] l, input logic [31:0] r,
                         input logic we, input logic [4:0] dest, input logic [2:0] memop);
        bus.ex_alusel      = sel;
        bus.ex_aluop       = op;
        bus.ex_srcLeft     = l;
        bus.ex_srcRight    = r;
        bus.ex_offset      = OFF;
        bus.ex_writeEnable = we;
        bus.ex_dest        = dest;
        bus.ex_memop       = memop;
    endtask

    // Push the expected EX/MEM result, present the op, hold it while stalled.
    task automatic issue(input string nm, input logic [2:0] sel, input logic [2:0] op,
                         input logic [31:0] l, input logic [31:0] r,
                         input logic we, input logic [4:0] dest, input logic [2:0] memop,
                         input logic [31:0] ewd, input logic ewe, input int estalls,
                         input bit chk_hl, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        bit   done;
        e.name = nm;   e.wdata = ewd;      e.addr = l + OFF;
        e.we = ewe;    e.dest = dest;      e.memop = memop;
        e.stalls = estalls; e.chk_hilo = chk_hl; e.hi = ehi; e.lo = elo;
        sbq.push_back(e);
        drive(sel, op, l, r, we, dest, memop);
        active = 1'b1;
        done   = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (!bus.stall_req) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: stall_req still high after 100 cycles", nm);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && active) begin
            if (bus.stall_req) begin
                stall_cnt++;
                checks++;
                if (bus.mem_wdata !== 32'd0 || bus.mem_writeEnable !== 1'b0 ||
                    bus.mem_dest !== 5'd0 || bus.mem_memop !== MEM_OP_NOP) begin
                    failures++;
                    $display("FAIL bubble: got wdata=%h we=%b dest=%0d memop=%0d expected all zero",
                             bus.mem_wdata, bus.mem_writeEnable, bus.mem_dest, bus.mem_memop);
                end
            end else if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got wdata=%h expected no pending op", bus.mem_wdata);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_stalls"}, 32'(stall_cnt), 32'(e.stalls));
                chk({e.name, "_wdata"}, bus.mem_wdata, e.wdata);
                chk({e.name, "_we"}, 32'(bus.mem_writeEnable), 32'(e.we));
                chk({e.name, "_dest"}, 32'(bus.mem_dest), 32'(e.dest));
                chk({e.name, "_memop"}, 32'(bus.mem_memop), 32'(e.memop));
                chk({e.name, "_addr"}, bus.mem_addr, e.addr);
                if (e.chk_hilo) begin
                    chk({e.name, "_hi"}, bus.hi, e.hi);
                    chk({e.name, "_lo"}, bus.lo, e.lo);
                end
                stall_cnt = 0;
            end
        end
    end

    initial begin
        // Reset with a live logic op on the inputs: every output must be forced to 0.
        drive(ALU_LOGIC, EX_LOGIC_OR, 32'h0000_FFFF, 32'h1111_0000, 1'b1, 5'd3, 3'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_we", 32'(bus.mem_writeEnable), 32'd0);
        chk("rst_dest", 32'(bus.mem_dest), 32'd0);
        chk("rst_memop", 32'(bus.mem_memop), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_stall", 32'(bus.stall_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(ALU_NOP, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, MEM_OP_NOP);
        @(negedge clk);
        chk("post_rst_hi", bus.hi, 32'd0);
        chk("post_rst_lo", bus.lo, 32'd0);
        @(posedge clk); #1;

        //     name      sel         op               L             R             we  dest memop wdata_exp     we_e st  hl  hi_exp        lo_exp
        issue("nor",   ALU_LOGIC,  EX_LOGIC_NOR,    32'h0F0F0000, 32'h00FF00FF, 1, 8, 0, 32'hF000FF00, 1, 0,  0, 0, 0);
        issue("and",   ALU_LOGIC,  EX_LOGIC_AND,    32'h0000F0F0, 32'h0000FF00, 1, 1, 2, 32'h0000F000, 1, 0,  0, 0, 0);
        issue("or",    ALU_LOGIC,  EX_LOGIC_OR,     32'h0000000F, 32'h000000F0, 0, 9, 3, 32'h000000FF, 0, 0,  0, 0, 0);
        issue("xor",   ALU_LOGIC,  EX_LOGIC_XOR,    32'h000000FF, 32'h0000000F, 1, 7, 0, 32'h000000F0, 1, 0,  0, 0, 0);
        issue("nop",   ALU_NOP,    3'd0,            32'h00001234, 32'h00005678, 1, 4, 0, 32'h00000000, 1, 0,  1, 0, 0);

        issue("mult",  ALU_MULDIV, EX_MULDIV_MULT,  32'hFFFFFFFE, 32'h00000003, 0, 5, 1, 32'h0,        0, 33, 0, 0, 0);
        issue("mflo1", ALU_MULDIV, EX_MULDIV_MFLO,  32'h0,        32'h0,        1, 2, 0, 32'hFFFFFFFA, 1, 0,  1, 32'hFFFFFFFF, 32'hFFFFFFFA);
        issue("mfhi1", ALU_MULDIV, EX_MULDIV_MFHI,  32'h0,        32'h0,        1, 3, 0, 32'hFFFFFFFF, 1, 0,  1, 32'hFFFFFFFF, 32'hFFFFFFFA);

        issue("multu", ALU_MULDIV, EX_MULDIV_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 5, 1, 32'h0,        0, 33, 0, 0, 0);
        issue("mfhi2", ALU_MULDIV, EX_MULDIV_MFHI,  32'h0,        32'h0,        1, 3, 0, 32'hFFFFFFFE, 1, 0,  1, 32'hFFFFFFFE, 32'h00000001);

        issue("div",   ALU_MULDIV, EX_MULDIV_DIV,   32'hFFFFFFF9, 32'h00000002, 0, 5, 1, 32'h0,        0, 33, 0, 0, 0);
        issue("mflo3", ALU_MULDIV, EX_MULDIV_MFLO,  32'h0,        32'h0,        1, 2, 0, 32'hFFFFFFFD, 1, 0,  1, 32'hFFFFFFFF, 32'hFFFFFFFD);

        issue("divu0", ALU_MULDIV, EX_MULDIV_DIVU,  32'd100,      32'h0,        0, 5, 1, 32'h0,        0, 33, 0, 0, 0);
        issue("mfhi4", ALU_MULDIV, EX_MULDIV_MFHI,  32'h0,        32'h0,        1, 3, 0, 32'd100,      1, 0,  1, 32'd100, 32'hFFFFFFFF);

        issue("divov", ALU_MULDIV, EX_MULDIV_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 5, 1, 32'h0,        0, 33, 0, 0, 0);
        issue("mflo5", ALU_MULDIV, EX_MULDIV_MFLO,  32'h0,        32'h0,        1, 2, 0, 32'h80000000, 1, 0,  1, 32'h0, 32'h80000000);

        issue("mtlo",  ALU_MULDIV, EX_MULDIV_MTLO,  32'h00000055, 32'h0,        1, 6, 0, 32'h0,        0, 0,  1, 32'h0, 32'h80000000);
        issue("mflo6", ALU_MULDIV, EX_MULDIV_MFLO,  32'h0,        32'h0,        1, 2, 0, 32'h00000055, 1, 0,  1, 32'h0, 32'h00000055);

        // Abort a DIV ten cycles in; HI/LO hold non-zero values beforehand.
        active = 1'b0;
        drive(ALU_MULDIV, EX_MULDIV_DIV, 32'd1000, 32'd7, 1'b0, 5'd5, 3'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("div_abort_busy", 32'(bus.stall_req), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_stall", 32'(bus.stall_req), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(ALU_NOP, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, MEM_OP_NOP);
        @(negedge clk);
        chk("released_stall", 32'(bus.stall_req), 32'd0);
        chk("released_hi", bus.hi, 32'd0);
        chk("released_lo", bus.lo, 32'd0);
        @(posedge clk); #1;
        stall_cnt = 0;

        issue("mthi",  ALU_MULDIV, EX_MULDIV_MTHI,  32'h00001234, 32'h0,        1, 6, 0, 32'h0,        0, 0,  1, 32'h0, 32'h0);
        issue("mfhi7", ALU_MULDIV, EX_MULDIV_MFHI,  32'h0,        32'h0,        1, 3, 0, 32'h00001234, 1, 0,  1, 32'h00001234, 32'h0);

        active = 1'b0;
        drive(ALU_NOP, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, MEM_OP_NOP);
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
